// File: rtl/led_row_scanner.sv
`default_nettype none
// ============================================================================
// Module      : led_row_scanner
// Description : Time-multiplexed row scanner for an 8x8 LED matrix.
//               Holds a double-buffered frame (buffers A/B, fsel picks the
//               front one), steps a row index 0..7 once every DIV cycles and
//               drives the matching column pattern after a BLANK-cycle
//               anti-ghosting gap. Back-buffer writes are free-running; a
//               swap request is deferred to the next frame boundary.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DIV         clock cycles per row slot (must be > BLANK+1)
//   BLANK       cycles at the start of each slot with columns off (>= 1)
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   wr_en       write strobe into the back buffer
//   wr_row      back-buffer row address
//   wr_data     column pattern for wr_row (bit i = column i lit)
//   swap_req    requests a front/back exchange at the next frame boundary
//   swap_ack    one-cycle pulse when the exchange happens
//   row_sel     row index to the 3-to-8 decoder (bit 3 always 0)
//   col         active-high column drive, 0 during blanking
//   frame_start one-cycle pulse while row 0 begins
// ============================================================================
module led_row_scanner #(
    parameter int DIV   = 6250,
    parameter int BLANK = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [2:0] wr_row,
    input  logic [7:0] wr_data,
    input  logic       swap_req,
    output logic       swap_ack,
    output logic [3:0] row_sel,
    output logic [7:0] col,
    output logic       frame_start
);

    localparam int            CW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);

    typedef enum logic [0:0] {
        S_BLANK = 1'b0,
        S_DRIVE = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [2:0]    row;
    logic [2:0]    row_nxt;
    logic          fsel;
    logic          pending;
    logic [7:0]    buf_a [8];
    logic [7:0]    buf_b [8];
    logic [7:0]    front_row;
    logic [7:0]    col_nxt;
    logic          slot_end;
    logic          frame_end;
    logic          swap_now;

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (row == 3'd7);
    // A request seen in the boundary cycle itself is honoured immediately.
    assign swap_now  = frame_end && (pending || swap_req);
    assign front_row = fsel ? buf_b[row] : buf_a[row];
    assign row_sel   = {1'b0, row};

    // Next-state / next-output logic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        row_nxt   = row;
        if (slot_end) begin
            cnt_nxt = '0;
            row_nxt = row + 3'd1;
        end
        case (state)
            S_BLANK: if (cnt_nxt >= CNT_BLANK) state_nxt = S_DRIVE;
            S_DRIVE: if (slot_end)             state_nxt = S_BLANK;
            default:                           state_nxt = S_BLANK;
        endcase
        // Row only advances on entry to BLANK, so the current row is the
        // right one whenever the next state is DRIVE.
        col_nxt = (state_nxt == S_DRIVE) ? front_row : 8'h00;
    end

    // Scan timing, outputs and swap control
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_BLANK;
            cnt         <= '0;
            row         <= 3'd0;
            col         <= 8'h00;
            frame_start <= 1'b0;
            swap_ack    <= 1'b0;
            fsel        <= 1'b0;
            pending     <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            row         <= row_nxt;
            col         <= col_nxt;
            frame_start <= frame_end;
            swap_ack    <= swap_now;
            if (swap_now) begin
                fsel    <= ~fsel;
                pending <= 1'b0;
            end else if (swap_req) begin
                pending <= 1'b1;
            end
        end
    end

    // Back-buffer writes; the back buffer is chosen by fsel before the edge,
    // so a write in the swap cycle lands in the buffer becoming front.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                buf_a[i] <= 8'h00;
                buf_b[i] <= 8'h00;
            end
        end else if (wr_en) begin
            if (fsel) buf_a[wr_row] <= wr_data;
            else      buf_b[wr_row] <= wr_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_led_row_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_row_scanner
// Description : Directed self-checking bench for led_row_scanner with
//               DIV=8, BLANK=2 (64-cycle frame).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_row_scanner;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       wr_en = 1'b0;
    logic [2:0] wr_row = 3'd0;
    logic [7:0] wr_data = 8'h00;
    logic       swap_req = 1'b0;
    logic       swap_ack;
    logic [3:0] row_sel;
    logic [7:0] col;
    logic       frame_start;

    led_row_scanner #(.DIV(8), .BLANK(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_row     (wr_row),
        .wr_data    (wr_data),
        .swap_req   (swap_req),
        .swap_ack   (swap_ack),
        .row_sel    (row_sel),
        .col        (col),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // expected-behaviour model
    int         m_cnt;
    logic [2:0] m_row;
    logic       m_fsel;
    logic       m_pend;
    logic [7:0] ea [8];
    logic [7:0] eb [8];

    // observation statistics
    int         n_fs, n_ack, n_colnz, n_ff, n_viol, n_b3, n_cyc, pat_bad;
    logic [3:0] prev_row;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_row = 3'd0; m_fsel = 1'b0; m_pend = 1'b0; prev_row = 4'd0;
        for (int i = 0; i < 8; i++) begin ea[i] = 8'h00; eb[i] = 8'h00; end
    endtask

    task automatic clear_stats();
        n_fs = 0; n_ack = 0; n_colnz = 0; n_ff = 0; n_cyc = 0;
    endtask

    // One clock: advance the model with the inputs seen at the edge, then
    // compare all outputs 1 time unit later.
    task automatic step();
        logic       boundary, swp;
        logic [7:0] e_col;
        @(posedge clk);
        boundary = (m_cnt == 7) && (m_row == 3'd7);
        if (wr_en) begin
            if (!m_fsel) eb[wr_row] = wr_data;
            else         ea[wr_row] = wr_data;
        end
        swp = boundary && (m_pend || swap_req);
        if (swp) begin m_fsel = ~m_fsel; m_pend = 1'b0; end
        else if (swap_req) m_pend = 1'b1;
        if (m_cnt == 7) begin m_cnt = 0; m_row = m_row + 3'd1; end
        else m_cnt++;
        #1;
        e_col = (m_cnt >= 2) ? (m_fsel ? eb[m_row] : ea[m_row]) : 8'h00;
        check("row_sel", 32'(row_sel), {29'd0, m_row});
        check("col", 32'(col), 32'(e_col));
        check("frame_start", 32'(frame_start), 32'(boundary));
        check("swap_ack", 32'(swap_ack), 32'(swp));
        n_cyc++;
        if (frame_start) n_fs++;
        if (swap_ack) n_ack++;
        if (col != 8'h00) n_colnz++;
        if (col == 8'hFF) n_ff++;
        if (row_sel != prev_row && col != 8'h00) n_viol++;
        if (row_sel[3]) n_b3++;
        prev_row = row_sel;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // advance until the model sits at (row r, count c); always within a frame
    task automatic run_to(input logic [2:0] r, input int c);
        for (int i = 0; i < 70 && !(m_row == r && m_cnt == c); i++) step();
    endtask

    task automatic wait_ack(input string tag);
        int k;
        k = 0;
        while (!swap_ack && k < 200) begin step(); k++; end
        check(tag, 32'(swap_ack), 32'd1);
    endtask

    int ack_at [3];

    initial begin
        model_reset();
        clear_stats();
        n_viol = 0; n_b3 = 0;

        // ---- reset values
        #1 rst_n = 1'b0;
        #2;
        check("rst_row_sel", 32'(row_sel), 32'd0);
        check("rst_col", 32'(col), 32'd0);
        check("rst_swap_ack", 32'(swap_ack), 32'd0);
        check("rst_frame_start", 32'(frame_start), 32'd0);
        #9 rst_n = 1'b1;                        // release at t=12

        // ---- idle scan
        run(130);
        check("idle_fs_count", 32'(n_fs), 32'd2);
        check("idle_col_zero", 32'(n_colnz), 32'd0);

        // ---- write pattern 1<<r, swap mid-frame
        for (int r = 0; r < 8; r++) begin
            wr_en = 1'b1; wr_row = 3'(r); wr_data = 8'h01 << r;
            step();
        end
        wr_en = 1'b0;
        run_to(3'd4, 0);
        swap_req = 1'b1; step(); swap_req = 1'b0;
        wait_ack("swap1_ack");
        check("ack_with_fs", 32'(frame_start), 32'd1);
        pat_bad = 0;
        for (int i = 0; i < 64; i++) begin
            step();
            if (col !== ((m_cnt >= 2) ? (8'h01 << row_sel[2:0]) : 8'h00)) pat_bad++;
        end
        check("pattern_frame", 32'(pat_bad), 32'd0);

        // ---- no tearing: overwrite back buffer during row 3
        run_to(3'd3, 2);
        clear_stats();
        for (int r = 0; r < 8; r++) begin
            wr_en = 1'b1; wr_row = 3'(r); wr_data = 8'hFF;
            step();
        end
        wr_en = 1'b0;
        run(64);
        check("no_tear_ff", 32'(n_ff), 32'd0);
        swap_req = 1'b1; step(); swap_req = 1'b0;
        wait_ack("swap2_ack");
        clear_stats();
        run(64);
        check("all_rows_ff", 32'(n_ff), 32'd48);

        // ---- swap_req held for three frames
        clear_stats();
        swap_req = 1'b1;
        while (n_ack < 3 && n_cyc < 300) begin
            step();
            if (swap_ack && n_ack <= 3) ack_at[n_ack-1] = n_cyc;
        end
        swap_req = 1'b0;
        check("held_ack_count", 32'(n_ack), 32'd3);
        check("held_gap1", 32'(ack_at[1] - ack_at[0]), 32'd64);
        check("held_gap2", 32'(ack_at[2] - ack_at[1]), 32'd64);
        run(10);

        // ---- write in the boundary cycle, together with a swap
        run_to(3'd7, 7);
        wr_en = 1'b1; wr_row = 3'd0; wr_data = 8'hA5; swap_req = 1'b1;
        step();
        wr_en = 1'b0; swap_req = 1'b0;
        check("boundary_ack", 32'(swap_ack), 32'd1);
        run(2);
        check("boundary_write_col", 32'(col), 32'hA5);

        // ---- mid-frame reset during row 5 DRIVE (front rows 1..7 are FF)
        run_to(3'd5, 4);
        check("pre_reset_col", 32'(col), 32'hFF);
        #2 rst_n = 1'b0;
        #1;
        check("async_row_sel", 32'(row_sel), 32'd0);
        check("async_col", 32'(col), 32'd0);
        check("async_fs", 32'(frame_start), 32'd0);
        @(posedge clk); @(posedge clk);
        #3 rst_n = 1'b1;
        model_reset();
        clear_stats();
        run(130);
        check("post_reset_fs_count", 32'(n_fs), 32'd2);
        check("post_reset_col_zero", 32'(n_colnz), 32'd0);

        // ---- random frames with writes and swaps
        for (int i = 0; i < 640; i++) begin
            wr_en    = 1'($urandom_range(1, 0));
            wr_row   = 3'($urandom_range(7, 0));
            wr_data  = 8'($urandom_range(255, 0));
            swap_req = ($urandom_range(39, 0) == 0);
            step();
        end
        wr_en = 1'b0; swap_req = 1'b0;
        check("blank_invariant", 32'(n_viol), 32'd0);
        check("row_sel_bit3", 32'(n_b3), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
